// File: rtl/memory_bus_arbiter.sv
// Two-port arbiter for the shared 32-bit memory bus: data-first with a
// fetch starvation guard, one transaction at a time, and a response timeout.
module memory_bus_arbiter #(
   parameter int MAX_DATA_STREAK = 4,
   parameter int TIMEOUT_CYCLES  = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_read_i,
   input  logic [31:0] i_address_i,
   output logic        i_response_o,
   output logic [31:0] i_read_data_o,
   input  logic        d_read_i,
   input  logic        d_write_i,
   input  logic [31:0] d_address_i,
   input  logic [31:0] d_write_data_i,
   output logic        d_response_o,
   output logic [31:0] d_read_data_o,
   output logic        mem_read_o,
   output logic        mem_write_o,
   output logic [31:0] mem_address_o,
   output logic [31:0] mem_write_data_o,
   input  logic        mem_response_i,
   input  logic [31:0] mem_read_data_i,
   output logic        bus_error_o,
   output logic [1:0]  grant_o
);

   localparam int SW = (MAX_DATA_STREAK > 0) ? $clog2(MAX_DATA_STREAK + 1) : 1;
   localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   typedef enum logic [1:0] {
      IDLE,
      GRANT_I,
      GRANT_D,
      RELEASE
   } state_e;

   state_e      state_q;
   logic [SW-1:0] streak_q;
   logic [SW-1:0] streak_d;
   logic [TW-1:0] tmo_q;
   logic        mem_read_q;
   logic        mem_write_q;
   logic [31:0] mem_addr_q;
   logic [31:0] mem_wdata_q;
   logic [1:0]  grant_q;

   logic d_req;
   logic starve;
   logic go_d;
   logic go_i;
   logic granted;
   logic tmo_hit;
   logic done;

   always_comb begin
      d_req   = d_read_i | d_write_i;
      starve  = i_read_i && (streak_q == SW'(MAX_DATA_STREAK));
      go_d    = d_req && !starve;
      go_i    = i_read_i && !go_d;
      granted = (state_q == GRANT_I) || (state_q == GRANT_D);
      tmo_hit = granted && !mem_response_i && (TIMEOUT_CYCLES != 0)
                && (tmo_q == TW'(TIMEOUT_CYCLES));
      done    = granted && (mem_response_i || tmo_hit);
      // Streak only grows while fetch is actually waiting behind data.
      if (!i_read_i)
         streak_d = '0;
      else if (streak_q == SW'(MAX_DATA_STREAK))
         streak_d = streak_q;
      else
         streak_d = streak_q + SW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         streak_q    <= '0;
         tmo_q       <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         grant_q     <= 2'b00;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (go_d) begin
                  state_q     <= GRANT_D;
                  grant_q     <= 2'b10;
                  mem_write_q <= d_write_i;
                  mem_read_q  <= !d_write_i;
                  mem_addr_q  <= d_address_i;
                  mem_wdata_q <= d_write_data_i;
                  streak_q    <= streak_d;
                  tmo_q       <= '0;
               end else if (go_i) begin
                  state_q     <= GRANT_I;
                  grant_q     <= 2'b01;
                  mem_write_q <= 1'b0;
                  mem_read_q  <= 1'b1;
                  mem_addr_q  <= i_address_i;
                  mem_wdata_q <= '0;
                  streak_q    <= '0;
                  tmo_q       <= '0;
               end
            end
            GRANT_I, GRANT_D: begin
               if (done) begin
                  state_q     <= RELEASE;
                  grant_q     <= 2'b00;
                  mem_write_q <= 1'b0;
                  mem_read_q  <= 1'b0;
                  mem_addr_q  <= '0;
                  mem_wdata_q <= '0;
               end else begin
                  tmo_q <= tmo_q + TW'(1);
               end
            end
            RELEASE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem_read_o       = mem_read_q;
   assign mem_write_o      = mem_write_q;
   assign mem_address_o    = mem_addr_q;
   assign mem_write_data_o = mem_wdata_q;
   assign grant_o          = grant_q;
   assign bus_error_o      = tmo_hit;

   assign i_response_o  = (state_q == GRANT_I) && done;
   assign d_response_o  = (state_q == GRANT_D) && done;
   assign i_read_data_o = ((state_q == GRANT_I) && mem_response_i)
                          ? mem_read_data_i : '0;
   assign d_read_data_o = ((state_q == GRANT_D) && mem_response_i)
                          ? mem_read_data_i : '0;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Bench for memory_bus_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_memory_bus_arbiter;

   localparam int MAXS = 4;
   localparam int TO   = 8;

   logic        clk;
   logic        rst;
   logic        i_read;
   logic [31:0] i_addr;
   logic        i_resp;
   logic [31:0] i_rdata;
   logic        d_read;
   logic        d_write;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_resp;
   logic [31:0] d_rdata;
   logic        m_rd;
   logic        m_wr_o;
   logic [31:0] m_ad;
   logic [31:0] m_wd;
   logic        m_resp;
   logic [31:0] m_rdata;
   logic        bus_err;
   logic [1:0]  grant;

   logic        auto_resp;
   logic        poke;
   logic [31:0] poke_data;
   logic [31:0] rd_val;
   bit          resp_en;
   int          lat;
   int          rcnt;
   bit          tb_done;

   int n_chk;
   int n_pass;

   assign m_resp  = auto_resp | poke;
   assign m_rdata = auto_resp ? rd_val : (poke ? poke_data : 32'h0);

   memory_bus_arbiter #(
      .MAX_DATA_STREAK(MAXS),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .i_read_i        (i_read),
      .i_address_i     (i_addr),
      .i_response_o    (i_resp),
      .i_read_data_o   (i_rdata),
      .d_read_i        (d_read),
      .d_write_i       (d_write),
      .d_address_i     (d_addr),
      .d_write_data_i  (d_wdata),
      .d_response_o    (d_resp),
      .d_read_data_o   (d_rdata),
      .mem_read_o      (m_rd),
      .mem_write_o     (m_wr_o),
      .mem_address_o   (m_ad),
      .mem_write_data_o(m_wd),
      .mem_response_i  (m_resp),
      .mem_read_data_i (m_rdata),
      .bus_error_o     (bus_err),
      .grant_o         (grant)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Memory model: answers `lat` cycles after the strobe first appears.
   initial begin
      auto_resp = 1'b0;
      rcnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (auto_resp) begin
            auto_resp = 1'b0;
            rcnt = 0;
         end else if (resp_en && (m_rd || m_wr_o)) begin
            if (rcnt == lat) auto_resp = 1'b1;
            else rcnt++;
         end else begin
            rcnt = 0;
         end
      end
   end

   // Transaction-level reference: who owns the bus, what it asked for,
   // how long it has waited, and how many data wins fetch has sat through.
   int          m_owner;
   bit          m_rel;
   int          m_age;
   int          m_streak;
   logic [31:0] m_addr;
   logic [31:0] m_wdat;
   bit          m_isw;
   bit          e_done;
   bit          e_err;

   initial begin
      m_owner = 0; m_rel = 0; m_age = 0; m_streak = 0;
      m_addr = 0; m_wdat = 0; m_isw = 0;
   end

   always @(negedge clk) begin
      if (!tb_done) begin
         e_err  = (m_owner != 0) && !m_resp && (m_age == TO);
         e_done = (m_owner != 0) && (m_resp || m_age == TO);
         chk("m.grant", 32'(grant), 32'(m_owner));
         chk("m.mem_read", 32'(m_rd), 32'((m_owner != 0) && !m_isw));
         chk("m.mem_write", 32'(m_wr_o), 32'((m_owner != 0) && m_isw));
         chk("m.mem_addr", m_ad, (m_owner != 0) ? m_addr : 32'h0);
         chk("m.mem_wdata", m_wd, (m_owner != 0) ? m_wdat : 32'h0);
         chk("m.bus_error", 32'(bus_err), 32'(e_err));
         chk("m.i_resp", 32'(i_resp), 32'(m_owner == 1 && e_done));
         chk("m.d_resp", 32'(d_resp), 32'(m_owner == 2 && e_done));
         chk("m.i_rdata", i_rdata,
             (m_owner == 1 && m_resp) ? m_rdata : 32'h0);
         chk("m.d_rdata", d_rdata,
             (m_owner == 2 && m_resp) ? m_rdata : 32'h0);
         if (rst) begin
            m_owner = 0; m_rel = 0; m_age = 0; m_streak = 0;
            m_addr = 0; m_wdat = 0; m_isw = 0;
         end else if (m_owner != 0) begin
            if (e_done) begin
               m_owner = 0;
               m_rel = 1;
            end else begin
               m_age++;
            end
         end else if (m_rel) begin
            m_rel = 0;
         end else if ((d_read || d_write) && !(i_read && m_streak == MAXS)) begin
            m_owner = 2;
            m_isw = d_write;
            m_addr = d_addr;
            m_wdat = d_wdata;
            m_age = 0;
            m_streak = i_read ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
         end else if (i_read) begin
            m_owner = 1;
            m_isw = 0;
            m_addr = i_addr;
            m_wdat = 0;
            m_age = 0;
            m_streak = 0;
         end
      end
   end

   int glog[$];
   logic [1:0] prev_g;
   initial prev_g = 2'b00;
   always @(negedge clk) begin
      if (grant != 2'b00 && prev_g == 2'b00) glog.push_back(int'(grant));
      prev_g = grant;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_resp(input bit is_d, input string nm);
      int n;
      n = 0;
      @(negedge clk);
      while (!(is_d ? d_resp : i_resp) && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk(nm, 32'(is_d ? d_resp : i_resp), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk = 0; n_pass = 0; tb_done = 0;
      rst = 1; i_read = 0; i_addr = 0; d_read = 0; d_write = 0;
      d_addr = 0; d_wdata = 0; poke = 0; poke_data = 0;
      rd_val = 0; resp_en = 1; lat = 2;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst.grant", 32'(grant), 32'd0);
      chk("rst.mem_read", 32'(m_rd), 32'd0);
      chk("rst.mem_addr", m_ad, 32'h0);
      tick();
      rst = 0;

      // fetch-only read, memory answers 2 cycles after the strobe rises
      tick();
      lat = 2; rd_val = 32'hDEADBEEF;
      i_read = 1; i_addr = 32'h100;
      @(negedge clk);
      chk("f.N.mem_read", 32'(m_rd), 32'd0);
      tick(); @(negedge clk);
      chk("f.N1.mem_read", 32'(m_rd), 32'd1);
      chk("f.N1.grant", 32'(grant), 32'd1);
      chk("f.N1.addr", m_ad, 32'h100);
      tick(); @(negedge clk);
      chk("f.N2.mem_read", 32'(m_rd), 32'd1);
      chk("f.N2.i_resp", 32'(i_resp), 32'd0);
      tick(); @(negedge clk);
      chk("f.N3.mem_read", 32'(m_rd), 32'd1);
      chk("f.N3.i_resp", 32'(i_resp), 32'd1);
      chk("f.N3.i_rdata", i_rdata, 32'hDEADBEEF);
      tick();
      i_read = 0;
      @(negedge clk);
      chk("f.N4.mem_read", 32'(m_rd), 32'd0);
      repeat (2) tick();

      // simultaneous fetch and data: data first, fetch after RELEASE
      lat = 1; rd_val = 32'h0000A5A5;
      i_read = 1; i_addr = 32'h104;
      d_read = 1; d_addr = 32'h200;
      @(negedge clk);
      chk("both.N.grant", 32'(grant), 32'd0);
      tick(); @(negedge clk);
      chk("both.N1.grant", 32'(grant), 32'd2);
      wait_resp(1, "both.d_resp");
      tick();
      d_read = 0;
      @(negedge clk);
      chk("both.rel.grant", 32'(grant), 32'd0);
      tick(); @(negedge clk);
      chk("both.idle.grant", 32'(grant), 32'd0);
      tick(); @(negedge clk);
      chk("both.fetch.grant", 32'(grant), 32'd1);
      wait_resp(0, "both.i_resp");
      tick();
      i_read = 0;
      repeat (3) tick();

      // streak guard with both requesters held high
      glog.delete();
      lat = 0;
      i_read = 1; i_addr = 32'h108;
      d_read = 1; d_addr = 32'h300;
      begin
         int n;
         n = 0;
         while (glog.size() < 10 && n < 300) begin
            @(negedge clk);
            n++;
         end
      end
      chk("streak.count", 32'(glog.size() >= 10), 32'd1);
      if (glog.size() >= 10) begin
         for (int k = 0; k < 10; k++)
            chk($sformatf("streak.g%0d", k), 32'(glog[k]),
                (k == 4 || k == 9) ? 32'd1 : 32'd2);
      end
      tick();
      i_read = 0; d_read = 0;
      repeat (6) tick();

      // read+write together behaves as a write
      lat = 1; rd_val = 32'h0;
      d_read = 1; d_write = 1; d_addr = 32'h204; d_wdata = 32'h12345678;
      tick(); @(negedge clk);
      chk("wr.mem_write", 32'(m_wr_o), 32'd1);
      chk("wr.mem_read", 32'(m_rd), 32'd0);
      chk("wr.wdata", m_wd, 32'h12345678);
      chk("wr.addr", m_ad, 32'h204);
      wait_resp(1, "wr.d_resp");
      tick();
      d_read = 0; d_write = 0;
      repeat (3) tick();

      // silent memory: timeout 8 cycles after grant
      resp_en = 0;
      d_read = 1; d_addr = 32'h300;
      tick(); @(negedge clk);
      chk("to.grant", 32'(grant), 32'd2);
      repeat (7) tick();
      @(negedge clk);
      chk("to.G7.err", 32'(bus_err), 32'd0);
      tick(); @(negedge clk);
      chk("to.G8.err", 32'(bus_err), 32'd1);
      chk("to.G8.d_resp", 32'(d_resp), 32'd1);
      chk("to.G8.d_rdata", d_rdata, 32'h0);
      tick();
      d_read = 0;
      @(negedge clk);
      chk("to.rel.mem_read", 32'(m_rd), 32'd0);
      repeat (3) tick();

      // reset mid-grant, then a normal fetch
      d_read = 1; d_addr = 32'h400;
      tick(); @(negedge clk);
      chk("rg.grant", 32'(grant), 32'd2);
      tick();
      rst = 1; d_read = 0;
      tick();
      rst = 0;
      @(negedge clk);
      chk("rg.grant0", 32'(grant), 32'd0);
      chk("rg.mem_read0", 32'(m_rd), 32'd0);
      chk("rg.d_resp0", 32'(d_resp), 32'd0);
      tick();
      resp_en = 1; lat = 1; rd_val = 32'hCAFEF00D;
      i_read = 1; i_addr = 32'h500;
      wait_resp(0, "rg.i_resp");
      chk("rg.i_rdata", i_rdata, 32'hCAFEF00D);
      tick();
      i_read = 0;
      repeat (3) tick();

      // stray memory response while idle
      resp_en = 0;
      poke = 1; poke_data = 32'h55;
      @(negedge clk);
      chk("idle.i_resp", 32'(i_resp), 32'd0);
      chk("idle.d_resp", 32'(d_resp), 32'd0);
      tick();
      poke = 0;
      repeat (3) tick();

      @(negedge clk);
      tb_done = 1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
